// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU phase sequencer: state encoding, default
// widths and the status readback offset.
package hpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } hpu_state_t;

    localparam int ADDR_W_DEF = 20;
    localparam int ITEM_W_DEF = 16;

    localparam logic [9:0] REG_STATUS_OFS = 10'h14;

    // Status word at REG_STATUS_OFS: {27'b0, timeout, done, state[2:0]}
    function automatic logic [31:0] status_word(hpu_state_t st, logic dn, logic to);
        return {27'd0, to, dn, st};
    endfunction

endpackage

// File: rtl/hpu_loop_cnt.sv
// Two-level j/i wrap counter for the compute phase; j is the inner index.
module hpu_loop_cnt #(
    parameter int W = 20
)(
    input  logic         AXIS_ACLK,
    input  logic         AXIS_ARESETN,
    input  logic         step,
    input  logic         clear,
    input  logic [W-1:0] lim_i,
    input  logic [W-1:0] lim_j,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic         last_j,
    output logic         last_all
);

    assign last_j   = (j == lim_j);
    assign last_all = last_j && (i == lim_i);

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            i <= '0;
            j <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
        end else if (step) begin
            if (last_j) begin
                j <= '0;
                i <= i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpu_seq.sv
// HPU phase sequencer: LOAD -> RUN -> DRAIN -> DONE on the stream clock.
// Optional perf counters enabled with `define HPU_SEQ_PERF_EN.
module hpu_seq
    import hpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ITEM_W   = ITEM_W_DEF,
    parameter int DRAIN_TO = 1024
)(
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESETN,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ITEM_W-1:0] cfg_item_num,
    input  logic [ADDR_W-1:0] cfg_num_i,
    input  logic [ADDR_W-1:0] cfg_num_j,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              dst_ready,
    input  logic              dst_idle,
    output logic              matw,
    output logic [ITEM_W-1:0] mat_a,
    output logic              src_v,
    output logic              exec,
    output logic              last_j,
    output logic              s_fin,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state_o
`ifdef HPU_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int DW = $clog2(DRAIN_TO + 1);

    hpu_state_t        state, next_state;
    logic [DW-1:0]     drain_cnt;
    logic              start_go, run_beat, drain_hit;
    logic              lc_last_j, lc_last_all;
    logic [ADDR_W-1:0] loop_i_unused, loop_j_unused;

    // A start that coincides with abort is dropped: abort wins.
    assign start_go  = cfg_start && !cfg_abort && (state == ST_IDLE);
    assign src_v     = src_valid && src_ready;
    assign run_beat  = (state == ST_RUN) && src_v && !cfg_abort;
    assign drain_hit = (drain_cnt == DW'(DRAIN_TO - 1));
    assign busy      = (state != ST_IDLE);
    assign state_o   = state;

    hpu_loop_cnt #(.W(ADDR_W)) u_loop (
        .AXIS_ACLK    (AXIS_ACLK),
        .AXIS_ARESETN (AXIS_ARESETN),
        .step         (run_beat),
        .clear        (start_go || cfg_abort),
        .lim_i        (cfg_num_i),
        .lim_j        (cfg_num_j),
        .i            (loop_i_unused),
        .j            (loop_j_unused),
        .last_j       (lc_last_j),
        .last_all     (lc_last_all)
    );

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) state <= ST_IDLE;
        else               state <= next_state;
    end

    // src_valid is used directly here (not src_v) to keep src_ready loop-free.
    always_comb begin
        next_state = state;
        src_ready  = 1'b0;
        matw       = 1'b0;
        case (state)
            ST_IDLE:  if (start_go) next_state = ST_LOAD;
            ST_LOAD: begin
                matw      = 1'b1;
                src_ready = 1'b1;
                if (src_valid && (mat_a == cfg_item_num)) next_state = ST_RUN;
            end
            ST_RUN: begin
                src_ready = dst_ready;
                if (src_valid && dst_ready && lc_last_all) next_state = ST_DRAIN;
            end
            ST_DRAIN: if (dst_idle || drain_hit) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (cfg_abort) next_state = ST_IDLE;
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            mat_a     <= '0;
            exec      <= 1'b0;
            last_j    <= 1'b0;
            s_fin     <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            exec   <= run_beat;
            last_j <= run_beat && lc_last_j;
            s_fin  <= run_beat && lc_last_all;

            // Hold at the last index instead of wrapping when item_num is all-ones.
            if (start_go || cfg_abort)
                mat_a <= '0;
            else if ((state == ST_LOAD) && src_valid && (mat_a != cfg_item_num))
                mat_a <= mat_a + 1'b1;

            if (state != ST_DRAIN || cfg_abort) drain_cnt <= '0;
            else                                drain_cnt <= drain_cnt + 1'b1;

            if (start_go) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if (next_state == ST_DONE) done <= 1'b1;
                if ((state == ST_DRAIN) && drain_hit && !dst_idle && !cfg_abort)
                    timeout <= 1'b1;
            end
        end
    end

`ifdef HPU_SEQ_PERF_EN
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (start_go) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if ((state == ST_LOAD || state == ST_RUN || state == ST_DRAIN) &&
                (perf_cycles != 32'hFFFF_FFFF))
                perf_cycles <= perf_cycles + 1'b1;
            if ((state == ST_RUN) && src_valid && !dst_ready)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hpu_seq.sv
// Randomized self-checking bench for hpu_seq against a job-level reference model.
module tb_hpu_seq;

    localparam int AW  = 20;
    localparam int IW  = 16;
    localparam int DTO = 16;

    logic          AXIS_ACLK = 1'b0;
    logic          AXIS_ARESETN = 1'b0;
    logic          cfg_start = 1'b0, cfg_abort = 1'b0;
    logic [IW-1:0] cfg_item_num = '0;
    logic [AW-1:0] cfg_num_i = '0, cfg_num_j = '0;
    logic          src_valid = 1'b0, dst_ready = 1'b0, dst_idle = 1'b1;
    logic          src_ready, matw, src_v, exec, last_j, s_fin, busy, done, timeout;
    logic [IW-1:0] mat_a;
    logic [2:0]    state_o;
`ifdef HPU_SEQ_PERF_EN
    logic [31:0]   perf_cycles, perf_stall;
`endif

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    hpu_seq #(.ADDR_W(AW), .ITEM_W(IW), .DRAIN_TO(DTO)) dut (
        .AXIS_ACLK    (AXIS_ACLK),
        .AXIS_ARESETN (AXIS_ARESETN),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_item_num (cfg_item_num),
        .cfg_num_i    (cfg_num_i),
        .cfg_num_j    (cfg_num_j),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .dst_ready    (dst_ready),
        .dst_idle     (dst_idle),
        .matw         (matw),
        .mat_a        (mat_a),
        .src_v        (src_v),
        .exec         (exec),
        .last_j       (last_j),
        .s_fin        (s_fin),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .state_o      (state_o)
`ifdef HPU_SEQ_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_stall   (perf_stall)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Observation records, sampled on the falling edge
    int         load_q[$];
    logic [1:0] ex_q[$];
    int         rdy_err, stall_cyc, act_cyc, drain_cyc, sfin_cnt;

    task automatic clr_mon();
        load_q.delete();
        ex_q.delete();
        rdy_err = 0; stall_cyc = 0; act_cyc = 0; drain_cyc = 0; sfin_cnt = 0;
    endtask

    always @(negedge AXIS_ACLK) begin
        if (AXIS_ARESETN) begin
            if (matw && src_v) load_q.push_back(int'(mat_a));
            if (exec) ex_q.push_back({last_j, s_fin});
            else if (last_j || s_fin) rdy_err++;
            if (s_fin) sfin_cnt++;
            if (src_ready !== ((state_o == 3'd1) ? 1'b1 : (state_o == 3'd2) ? dst_ready : 1'b0))
                rdy_err++;
            if (matw !== (state_o == 3'd1)) rdy_err++;
            if (src_v !== (src_valid && src_ready)) rdy_err++;
            if (state_o == 3'd2 && src_valid && !dst_ready) stall_cyc++;
            if (state_o >= 3'd1 && state_o <= 3'd3) act_cyc++;
            if (state_o == 3'd3) drain_cyc++;
        end
    end

    task automatic pulse_start();
        @(posedge AXIS_ACLK); #1 cfg_start = 1'b1;
        @(posedge AXIS_ACLK); #1 cfg_start = 1'b0;
    endtask

    // mode 0: valid/ready high; 1: ready toggles; 2: random; 3: dst_idle stuck low
    task automatic run_job(input int it, input int ni, input int nj, input int mode, input string nm);
        int  d, drn, total;
        bit  tgl, ok;
        logic [1:0] e;
        d = $urandom_range(4, 0);
        drn = 0; tgl = 1'b1; ok = 1'b0;
        total = (ni + 1) * (nj + 1);
        clr_mon();
        cfg_item_num = IW'(it);
        cfg_num_i = AW'(ni);
        cfg_num_j = AW'(nj);
        src_valid = 1'b0;
        dst_ready = 1'b1;
        pulse_start();
        chk({nm, "_st_load"}, 32'(state_o), 32'd1);
        chk({nm, "_done_clr"}, 32'(done), 32'd0);
        for (int c = 0; c < 3000; c++) begin
            case (mode)
                1: begin src_valid = 1'b1; dst_ready = tgl; tgl = ~tgl; end
                2: begin src_valid = 1'($urandom); dst_ready = 1'($urandom); end
                default: begin src_valid = 1'b1; dst_ready = 1'b1; end
            endcase
            if (state_o == 3'd3) begin
                dst_idle = (mode == 3) ? 1'b0 : (drn >= d);
                drn++;
            end else begin
                dst_idle = 1'b1;
            end
            @(negedge AXIS_ACLK);
            if (state_o == 3'd0) begin ok = 1'b1; break; end
            @(posedge AXIS_ACLK); #1;
        end
        #1;
        src_valid = 1'b0;
        dst_idle = 1'b1;
        chk({nm, "_finished"}, 32'(ok), 32'd1);
        chk({nm, "_load_n"}, 32'(load_q.size()), 32'(it + 1));
        for (int k = 0; k < load_q.size() && k <= it; k++)
            chk({nm, "_mat_a"}, 32'(load_q[k]), 32'(k));
        chk({nm, "_exec_n"}, 32'(ex_q.size()), 32'(total));
        for (int k = 0; k < ex_q.size() && k < total; k++) begin
            e = {((k + 1) % (nj + 1) == 0), (k + 1 == total)};
            chk({nm, "_lj_sfin"}, 32'(ex_q[k]), 32'(e));
        end
        chk({nm, "_sfin_n"}, 32'(sfin_cnt), 32'd1);
        chk({nm, "_ifc"}, 32'(rdy_err), 32'd0);
        chk({nm, "_drain_cyc"}, 32'(drain_cyc), (mode == 3) ? 32'(DTO) : 32'(d + 1));
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_timeout"}, 32'(timeout), (mode == 3) ? 32'd1 : 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
`ifdef HPU_SEQ_PERF_EN
        chk({nm, "_perf_stall"}, perf_stall, 32'(stall_cyc));
        chk({nm, "_perf_cycles"}, perf_cycles, 32'(act_cyc));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_mon();
        repeat (3) @(posedge AXIS_ACLK);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_outs", 32'({matw, src_ready, src_v, exec, last_j, s_fin, busy, done, timeout}), 32'd0);
        chk("rst_mat_a", 32'(mat_a), 32'd0);
        AXIS_ARESETN = 1'b1;

        run_job(3, 1, 2, 0, "base");
        run_job(3, 1, 2, 1, "tgl");
        run_job(0, 0, 0, 0, "one");
        run_job(0, 0, 0, 3, "tmo");

        // abort on the second RUN beat
        clr_mon();
        cfg_item_num = 16'd3; cfg_num_i = 20'd1; cfg_num_j = 20'd2;
        src_valid = 1'b1; dst_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 50; c++) begin
            if (state_o == 3'd2) break;
            @(posedge AXIS_ACLK); #1;
        end
        chk("abort_in_run", 32'(state_o), 32'd2);
        @(posedge AXIS_ACLK); #1 cfg_abort = 1'b1;
        @(posedge AXIS_ACLK); #1 cfg_abort = 1'b0;
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge AXIS_ACLK);
        #1;
        chk("abort_no_sfin", 32'(sfin_cnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        src_valid = 1'b0;
        run_job(3, 1, 2, 0, "restart");

        // start and abort together from IDLE
        @(posedge AXIS_ACLK); #1 cfg_start = 1'b1; cfg_abort = 1'b1;
        @(posedge AXIS_ACLK); #1 cfg_start = 1'b0; cfg_abort = 1'b0;
        chk("sa_state", 32'(state_o), 32'd0);
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_done_kept", 32'(done), 32'd1);

        // async reset between clock edges mid-LOAD
        cfg_item_num = 16'd7;
        src_valid = 1'b1;
        pulse_start();
        @(posedge AXIS_ACLK); #1;
        chk("arst_pre_matw", 32'(matw), 32'd1);
        @(negedge AXIS_ACLK); #2 AXIS_ARESETN = 1'b0;
        #1;
        chk("arst_outs", 32'({matw, src_ready, busy}), 32'd0);
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_mat_a", 32'(mat_a), 32'd0);
        #1 AXIS_ARESETN = 1'b1;
        src_valid = 1'b0;
        run_job(2, 1, 1, 2, "post_rst");

        for (int r = 0; r < 8; r++)
            run_job($urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(3, 0), 2, "rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
